// File: rtl/vend_controller.sv
// vend_controller: coin-path sequencing controller for the vending machine.
// It collects credit from the coin mux. On a buy request it dispenses one item
// when the credit covers PRICE, then returns any remaining credit as a series
// of single-coin change pulses. It also drives the running credit for the
// display.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   coin_strobe  one-cycle pulse: coin_val is valid this cycle
//   coin_val     coin value in cents (0 = coin rejected by the mux)
//   buy          one-cycle purchase request
//   cancel       one-cycle full-refund request
//   credit       current credit in cents (registered)
//   busy         high whenever the controller is not in IDLE
//   vend         one-cycle dispense pulse
//   coin_reject  one-cycle pulse: the strobed coin was not accepted
//   change_q/d/n one-cycle pulse: return one quarter / dime / nickel
module vend_controller #(
  parameter logic [7:0] PRICE      = 8'd65,
  parameter logic [7:0] MAX_CREDIT = 8'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_strobe,
  input  logic [7:0] coin_val,
  input  logic       buy,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       busy,
  output logic       vend,
  output logic       coin_reject,
  output logic       change_q,
  output logic       change_d,
  output logic       change_n
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       vend_q, vend_d;
  logic       reject_q, reject_d;
  logic       qtr_q, qtr_d;
  logic       dime_q, dime_d;
  logic       nick_q, nick_d;

  logic       coin_ok;
  logic [8:0] coin_sum;
  logic [7:0] change_left;

  // The sum is one bit wider than credit so an oversized coin cannot wrap
  // around and slip under the ceiling.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_ok  = ((coin_val == 8'd5) || (coin_val == 8'd10) || (coin_val == 8'd25))
                    && (coin_sum <= {1'b0, MAX_CREDIT});

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    vend_d      = 1'b0;
    reject_d    = 1'b0;
    qtr_d       = 1'b0;
    dime_d      = 1'b0;
    nick_d      = 1'b0;
    change_left = credit_q;

    case (state_q)
      IDLE: begin
        // A coin is taken only on a cycle with no buy or cancel. Otherwise it
        // is bounced, so coin acceptance and purchase never both change credit.
        if (coin_strobe) begin
          if (coin_ok && !buy && !cancel) begin
            credit_d = coin_sum[7:0];
          end else begin
            reject_d = 1'b1;
          end
        end
        if (cancel) begin
          state_d = CHANGE;
        end else if (buy && (credit_q >= PRICE)) begin
          state_d  = DISPENSE;
          credit_d = credit_q - PRICE;
          vend_d   = 1'b1;
        end
      end

      DISPENSE: begin
        reject_d = coin_strobe;
        state_d  = (credit_q != 8'd0) ? CHANGE : IDLE;
      end

      CHANGE: begin
        reject_d = coin_strobe;
        if (credit_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          if (credit_q >= 8'd25) begin
            change_left = credit_q - 8'd25;
            qtr_d       = 1'b1;
          end else if (credit_q >= 8'd10) begin
            change_left = credit_q - 8'd10;
            dime_d      = 1'b1;
          end else begin
            change_left = credit_q - 8'd5;
            nick_d      = 1'b1;
          end
          credit_d = change_left;
          // Leave on the same edge as the last coin so busy drops with it.
          if (change_left == 8'd0) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      vend_q   <= 1'b0;
      reject_q <= 1'b0;
      qtr_q    <= 1'b0;
      dime_q   <= 1'b0;
      nick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= vend_d;
      reject_q <= reject_d;
      qtr_q    <= qtr_d;
      dime_q   <= dime_d;
      nick_q   <= nick_d;
    end
  end

  assign credit      = credit_q;
  assign busy        = (state_q != IDLE);
  assign vend        = vend_q;
  assign coin_reject = reject_q;
  assign change_q    = qtr_q;
  assign change_d    = dime_q;
  assign change_n    = nick_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed testbench for vend_controller. Every expected value is computed by
// hand from the controller's behaviour. Pulse outputs are grouped as
// {vend, coin_reject, change_q, change_d, change_n}.
module tb_vend_controller;

  logic       clk;
  logic       reset;
  logic       coin_strobe;
  logic [7:0] coin_val;
  logic       buy;
  logic       cancel;
  logic [7:0] credit;
  logic       busy;
  logic       vend;
  logic       coin_reject;
  logic       change_q;
  logic       change_d;
  logic       change_n;

  int unsigned n_checks;
  int unsigned n_errors;

  vend_controller #(
    .PRICE      (8'd65),
    .MAX_CREDIT (8'd100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_strobe (coin_strobe),
    .coin_val    (coin_val),
    .buy         (buy),
    .cancel      (cancel),
    .credit      (credit),
    .busy        (busy),
    .vend        (vend),
    .coin_reject (coin_reject),
    .change_q    (change_q),
    .change_d    (change_d),
    .change_n    (change_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Check credit, busy and the pulse group in one call.
  task automatic expect_out(input string tag, input int unsigned exp_credit,
                            input int unsigned exp_busy, input logic [4:0] exp_pulses);
    check({tag, ".credit"}, credit, exp_credit);
    check({tag, ".busy"}, busy, exp_busy);
    check({tag, ".pulses"}, {vend, coin_reject, change_q, change_d, change_n}, exp_pulses);
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [7:0] v);
    coin_strobe = 1'b1;
    coin_val    = v;
    tick();
    coin_strobe = 1'b0;
    coin_val    = '0;
  endtask

  task automatic press_buy();
    buy = 1'b1;
    tick();
    buy = 1'b0;
  endtask

  task automatic press_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    coin_strobe = 1'b0;
    coin_val    = '0;
    buy         = 1'b0;
    cancel      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    expect_out("reset", 0, 0, 5'b00000);

    // Coin accumulation 25, 25, 10 gives 60, then 10 and 5 give 75.
    coin(8'd25); expect_out("coin25a", 25, 0, 5'b00000);
    coin(8'd25); expect_out("coin25b", 50, 0, 5'b00000);
    coin(8'd10); expect_out("coin10",  60, 0, 5'b00000);
    coin(8'd10); expect_out("coin10b", 70, 0, 5'b00000);
    coin(8'd5);  expect_out("coin5",   75, 0, 5'b00000);

    // Buy at 75: vend with credit 10, one DISPENSE cycle, then a single dime.
    press_buy(); expect_out("buy75.vend", 10, 1, 5'b10000);
    tick();      expect_out("buy75.disp", 10, 1, 5'b00000);
    tick();      expect_out("buy75.dime", 0, 0, 5'b00010);
    tick();      expect_out("buy75.idle", 0, 0, 5'b00000);

    // Exact price: vend, then straight back to IDLE with no change.
    coin(8'd25); coin(8'd25); coin(8'd10); coin(8'd5);
    expect_out("load65", 65, 0, 5'b00000);
    press_buy(); expect_out("buy65.vend", 0, 1, 5'b10000);
    tick();      expect_out("buy65.idle", 0, 0, 5'b00000);
    tick();      expect_out("buy65.quiet", 0, 0, 5'b00000);

    // Below price: buy is ignored.
    coin(8'd25); coin(8'd25); coin(8'd10);
    press_buy(); expect_out("buy60", 60, 0, 5'b00000);

    // Ceiling and invalid coins at credit 90.
    coin(8'd25); coin(8'd5);
    expect_out("load90", 90, 0, 5'b00000);
    coin(8'd25); expect_out("over", 90, 0, 5'b01000);
    tick();      expect_out("over.clr", 90, 0, 5'b00000);
    coin(8'd0);  expect_out("zero", 90, 0, 5'b01000);
    coin(8'd7);  expect_out("seven", 90, 0, 5'b01000);
    coin(8'd10); expect_out("exact100", 100, 0, 5'b00000);
    coin(8'd5);  expect_out("over105", 100, 0, 5'b01000);

    // Cancel at 100 refunds four quarters.
    press_cancel(); expect_out("can100", 100, 1, 5'b00000);
    tick(); expect_out("can100.q1", 75, 1, 5'b00100);
    tick(); expect_out("can100.q2", 50, 1, 5'b00100);
    tick(); expect_out("can100.q3", 25, 1, 5'b00100);
    tick(); expect_out("can100.q4", 0, 0, 5'b00100);

    // Cancel at 40 refunds a quarter, a dime and a nickel back-to-back.
    coin(8'd25); coin(8'd10); coin(8'd5);
    press_cancel(); expect_out("can40", 40, 1, 5'b00000);
    tick(); expect_out("can40.q", 15, 1, 5'b00100);
    tick(); expect_out("can40.d", 5, 1, 5'b00010);
    tick(); expect_out("can40.n", 0, 0, 5'b00001);
    tick(); expect_out("can40.idle", 0, 0, 5'b00000);

    // Cancel on empty credit: one busy cycle, no pulses.
    press_cancel(); expect_out("can0", 0, 1, 5'b00000);
    tick();         expect_out("can0.idle", 0, 0, 5'b00000);

    // buy and cancel together at 65: cancel wins and the full 65 is refunded.
    coin(8'd25); coin(8'd25); coin(8'd10); coin(8'd5);
    buy = 1'b1; cancel = 1'b1;
    tick();
    buy = 1'b0; cancel = 1'b0;
    expect_out("bc65", 65, 1, 5'b00000);
    tick(); expect_out("bc65.q1", 40, 1, 5'b00100);
    tick(); expect_out("bc65.q2", 15, 1, 5'b00100);
    tick(); expect_out("bc65.d", 5, 1, 5'b00010);
    tick(); expect_out("bc65.n", 0, 0, 5'b00001);

    // buy with a coin strobe at 65: coin bounced, buy processed. A coin
    // during the DISPENSE cycle is also bounced.
    coin(8'd25); coin(8'd25); coin(8'd10); coin(8'd5);
    buy = 1'b1; coin_strobe = 1'b1; coin_val = 8'd5;
    tick();
    buy = 1'b0;
    expect_out("buycoin", 0, 1, 5'b11000);
    tick();
    coin_strobe = 1'b0; coin_val = '0;
    expect_out("dispcoin", 0, 0, 5'b01000);

    // Reset during the first change pulse after a buy at 100.
    coin(8'd25); coin(8'd25); coin(8'd25); coin(8'd25);
    press_buy(); expect_out("buy100.vend", 35, 1, 5'b10000);
    tick();      expect_out("buy100.disp", 35, 1, 5'b00000);
    tick();      expect_out("buy100.q", 10, 1, 5'b00100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("midreset", 0, 0, 5'b00000);
    tick();      expect_out("midreset.quiet", 0, 0, 5'b00000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
